// File: rtl/upg_if.sv
// Instruction-memory programming port driven by the UART loader.
// Holds the programmer reset, write strobe, word address and write data.
interface upg_if;
  logic        upg_rst_o;
  logic        upg_wen_o;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;

  modport master (output upg_rst_o, output upg_wen_o, output upg_adr_o, output upg_dat_o);
  modport slave  (input  upg_rst_o, input  upg_wen_o, input  upg_adr_o, input  upg_dat_o);
endinterface

// File: rtl/upg_loader.sv
// UART boot loader: receives a 16-bit little-endian word count followed by
// 32-bit little-endian words and writes them to instruction memory from address 0.
module upg_loader #(
  parameter int CLK_FREQ_HZ  = 10000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        rx_i,
  upg_if.master       upg,
  output logic        upg_done_o,
  output logic        err_o,
  output logic [14:0] words_o,
  output logic [2:0]  main_state_o,
  output logic [1:0]  rx_state_o,
  output logic        byte_valid_o
);

  // Write port: upg_wen_o is a single-cycle strobe. upg_adr_o/upg_dat_o are
  // valid only in that cycle; the memory has no back-pressure (always ready).

  localparam int BIT_CLKS  = CLK_FREQ_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR} main_state_t;

  rx_state_t   rx_state;
  main_state_t state;

  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_valid;
  logic        frame_err;

  logic [15:0] count;
  logic [15:0] cnt_full;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [31:0] timer;

  assign cnt_full     = {shreg, count[7:0]};
  assign main_state_o = state;
  assign rx_state_o   = rx_state;
  assign byte_valid_o = byte_valid;

  // Receiver: shreg holds the last byte until the next one is shifted in.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx_i;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (bit_cnt == 16'(HALF_CLKS - 1)) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == 16'(BIT_CLKS - 1)) begin
            bit_cnt <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == 16'(BIT_CLKS - 1)) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) byte_valid <= 1'b1;
            else frame_err <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      upg.upg_rst_o  <= 1'b1;
      upg.upg_wen_o  <= 1'b0;
      upg.upg_adr_o  <= '0;
      upg.upg_dat_o  <= '0;
      upg_done_o     <= 1'b0;
      err_o          <= 1'b0;
      words_o        <= '0;
      count          <= '0;
      byte_idx       <= '0;
      word           <= '0;
      timer          <= '0;
    end else begin
      upg.upg_wen_o <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state         <= CNT_LO;
            upg.upg_rst_o <= 1'b0;
            upg_done_o    <= 1'b0;
            err_o         <= 1'b0;
            words_o       <= '0;
            byte_idx      <= '0;
            word          <= '0;
            timer         <= '0;
          end
        end
        CNT_LO: begin
          if (frame_err) begin
            state <= ERR; err_o <= 1'b1; upg.upg_rst_o <= 1'b1;
          end else if (byte_valid) begin
            count[7:0] <= shreg;
            timer      <= '0;
            state      <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (frame_err) begin
            state <= ERR; err_o <= 1'b1; upg.upg_rst_o <= 1'b1;
          end else if (byte_valid) begin
            count <= cnt_full;
            timer <= '0;
            if (cnt_full == 16'd0) begin
              state <= DONE; upg_done_o <= 1'b1; upg.upg_rst_o <= 1'b1;
            end else if (cnt_full > 16'd16384) begin
              state <= ERR; err_o <= 1'b1; upg.upg_rst_o <= 1'b1;
            end else begin
              state <= DATA;
            end
          end else if (timer == 32'(TIMEOUT_CLKS - 1)) begin
            state <= ERR; err_o <= 1'b1; upg.upg_rst_o <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        DATA: begin
          // Completion is decided the cycle after the final write, so the
          // write cycle itself is never masked by the DONE transition.
          if (upg.upg_wen_o && ({1'b0, words_o} == count)) begin
            state <= DONE; upg_done_o <= 1'b1; upg.upg_rst_o <= 1'b1;
          end else if (frame_err) begin
            state <= ERR; err_o <= 1'b1; upg.upg_rst_o <= 1'b1;
          end else if (byte_valid) begin
            timer    <= '0;
            word     <= {shreg, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              upg.upg_wen_o <= 1'b1;
              upg.upg_adr_o <= words_o[13:0];
              upg.upg_dat_o <= {shreg, word[31:8]};
              words_o       <= words_o + 15'd1;
            end
          end else if (timer == 32'(TIMEOUT_CLKS - 1)) begin
            state <= ERR; err_o <= 1'b1; upg.upg_rst_o <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          state <= IDLE; upg.upg_rst_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
